// File: rtl/cia_serial_link.sv
// ---------------------------------------------------------------------------
// cia_serial_link
//
// Peer endpoint for a CIA serial port (SP/CNT pins). Bytes the CIA shifts out
// in output mode are deserialized into a small RX FIFO with a valid/ready
// consumer interface. Bytes offered on the TX valid/ready interface are
// serialized MSB-first onto sp_in/cnt_in so a CIA in input mode receives them.
// The two paths are fully independent.
//
// Optional build macro: CIA_LINK_LOOPBACK_EN
//   When defined, a 'loopback' input is added. With loopback=1 the RX path
//   listens to the internal TX sp/cnt and the CIA-facing outputs are parked
//   high.
//
// Ports:
//   clk          system clock
//   res_n        asynchronous active-low reset
//   loopback     (CIA_LINK_LOOPBACK_EN only) route TX back into RX
//   cia_sp_out   CIA SP output (serial data into this block)
//   cia_cnt_out  CIA CNT output (shift clock, idle high)
//   cia_sp_in    drives CIA SP input
//   cia_cnt_in   drives CIA CNT input
//   rx_data      RX FIFO head byte
//   rx_valid     RX FIFO not empty
//   rx_ready     consumer pops head when rx_valid & rx_ready
//   rx_overrun   one-cycle pulse: received byte dropped, FIFO full
//   tx_data      byte to send
//   tx_valid     byte offered
//   tx_ready     transmitter idle; byte accepted on tx_valid & tx_ready
//   tx_busy      transmission in progress
// ---------------------------------------------------------------------------
module cia_serial_link #(
  parameter int CNT_DIV      = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       res_n,
`ifdef CIA_LINK_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       cia_sp_out,
  input  logic       cia_cnt_out,
  output logic       cia_sp_in,
  output logic       cia_cnt_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy
);

  localparam int DIV_W = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CNT_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOW  = 2'd1,
    TX_HIGH = 2'd2,
    TX_GAP  = 2'd3
  } tx_state_e;

  // ------------------------------------------------------------------ loopback
  logic lb_s;
`ifdef CIA_LINK_LOOPBACK_EN
  assign lb_s = loopback;
`else
  assign lb_s = 1'b0;
`endif

  // TX line state (internal, before the loopback gate on the CIA pins)
  logic tx_sp_q, tx_sp_d;
  logic tx_cnt_q, tx_cnt_d;
  logic cia_sp_in_q, cia_cnt_in_q;

  logic rx_sp_src_s, rx_cnt_src_s;
  assign rx_sp_src_s  = lb_s ? tx_sp_q  : cia_sp_out;
  assign rx_cnt_src_s = lb_s ? tx_cnt_q : cia_cnt_out;

  // ------------------------------------------------------------ synchronizers
  logic cnt_s1_q, cnt_s2_q, cnt_prev_q;
  logic sp_s1_q, sp_s2_q;

  // Two-flop synchronizers for SP/CNT plus a delayed CNT copy for edge detect
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_s1_q   <= 1'b1;
      cnt_s2_q   <= 1'b1;
      cnt_prev_q <= 1'b1;
      sp_s1_q    <= 1'b1;
      sp_s2_q    <= 1'b1;
    end else begin
      cnt_s1_q   <= rx_cnt_src_s;
      cnt_s2_q   <= cnt_s1_q;
      cnt_prev_q <= cnt_s2_q;
      sp_s1_q    <= rx_sp_src_s;
      sp_s2_q    <= sp_s1_q;
    end
  end

  logic rx_rise_s, rx_edge_s;
  assign rx_rise_s = cnt_s2_q & ~cnt_prev_q;
  assign rx_edge_s = cnt_s2_q ^ cnt_prev_q;

  // ------------------------------------------------------------- deserializer
  logic [7:0]      rx_shreg_q, rx_shreg_d;
  logic [2:0]      rx_bits_q, rx_bits_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic            push_q, push_d;
  logic [7:0]      push_byte_q, push_byte_d;

  // Shift on CNT rising edges; abandon a partial byte after a long CNT-high idle
  always_comb begin
    rx_shreg_d  = rx_shreg_q;
    rx_bits_d   = rx_bits_q;
    idle_d      = idle_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    if (rx_rise_s) begin
      rx_shreg_d = {rx_shreg_q[6:0], sp_s2_q};
      rx_bits_d  = rx_bits_q + 3'd1;
      if (rx_bits_q == 3'd7) begin
        push_d      = 1'b1;
        push_byte_d = {rx_shreg_q[6:0], sp_s2_q};
      end else begin
        push_d      = 1'b0;
      end
    end else begin
      rx_shreg_d = rx_shreg_q;
    end
    // A low CNT holds the timeout; only a stalled-high line counts as idle.
    if (rx_edge_s) begin
      idle_d = '0;
    end else if ((rx_bits_q != 3'd0) && cnt_s2_q) begin
      if (idle_q == TO_LAST) begin
        idle_d     = '0;
        rx_bits_d  = 3'd0;
        rx_shreg_d = 8'h00;
      end else begin
        idle_d     = idle_q + TO_W'(1);
      end
    end else if (rx_bits_q == 3'd0) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q;
    end
  end

  // Deserializer state registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_shreg_q  <= 8'h00;
      rx_bits_q   <= 3'd0;
      idle_q      <= '0;
      push_q      <= 1'b0;
      push_byte_q <= 8'h00;
    end else begin
      rx_shreg_q  <= rx_shreg_d;
      rx_bits_q   <= rx_bits_d;
      idle_q      <= idle_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
    end
  end

  // ------------------------------------------------------------------ RX FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q;
  logic             fifo_full_s, fifo_pop_s, fifo_wr_s, overrun_d;

  assign fifo_full_s = (count_q == FIFO_FULL);
  assign fifo_pop_s  = rx_ready & (count_q != '0);
  // When full, a same-cycle pop frees the slot the push needs.
  assign fifo_wr_s   = push_q & (~fifo_full_s | fifo_pop_s);
  assign overrun_d   = push_q & fifo_full_s & ~fifo_pop_s;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({fifo_wr_s, fifo_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers, occupancy and overrun pulse
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (fifo_wr_s) begin
        mem_q[wr_ptr_q] <= push_byte_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign rx_valid   = (count_q != '0);
  assign rx_overrun = overrun_q;

  // ------------------------------------------------------------------- TX FSM
  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       tx_shreg_q, tx_shreg_d;
  logic [2:0]       tx_bit_q, tx_bit_d;

  // TX next-state: each phase lasts CNT_DIV cycles, timed by one down-counter
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tx_shreg_d = tx_shreg_q;
    tx_bit_d   = tx_bit_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          state_d    = TX_LOW;
          div_d      = DIV_RELOAD;
          tx_shreg_d = tx_data;
          tx_bit_d   = 3'd0;
        end else begin
          state_d    = TX_IDLE;
        end
      end
      TX_LOW: begin
        if (div_q == '0) begin
          state_d = TX_HIGH;
          div_d   = DIV_RELOAD;
        end else begin
          div_d   = div_q - DIV_W'(1);
        end
      end
      TX_HIGH: begin
        if (div_q == '0) begin
          div_d      = DIV_RELOAD;
          tx_shreg_d = {tx_shreg_q[6:0], 1'b0};
          tx_bit_d   = tx_bit_q + 3'd1;
          state_d    = (tx_bit_q == 3'd7) ? TX_GAP : TX_LOW;
        end else begin
          div_d      = div_q - DIV_W'(1);
        end
      end
      TX_GAP: begin
        if (div_q == '0) begin
          state_d = TX_IDLE;
          div_d   = DIV_RELOAD;
        end else begin
          div_d   = div_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        div_d   = DIV_RELOAD;
      end
    endcase
    // Line values follow the next state so the pins change with the state.
    tx_cnt_d = (state_d != TX_LOW);
    if ((state_d == TX_LOW) || (state_d == TX_HIGH)) begin
      tx_sp_d = tx_shreg_d[7];
    end else begin
      tx_sp_d = 1'b1;
    end
  end

  // TX state, divider, shift register and registered line/pin drivers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= TX_IDLE;
      div_q        <= DIV_RELOAD;
      tx_shreg_q   <= 8'h00;
      tx_bit_q     <= 3'd0;
      tx_sp_q      <= 1'b1;
      tx_cnt_q     <= 1'b1;
      cia_sp_in_q  <= 1'b1;
      cia_cnt_in_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      tx_shreg_q   <= tx_shreg_d;
      tx_bit_q     <= tx_bit_d;
      tx_sp_q      <= tx_sp_d;
      tx_cnt_q     <= tx_cnt_d;
      cia_sp_in_q  <= lb_s ? 1'b1 : tx_sp_d;
      cia_cnt_in_q <= lb_s ? 1'b1 : tx_cnt_d;
    end
  end

  assign cia_sp_in  = cia_sp_in_q;
  assign cia_cnt_in = cia_cnt_in_q;
  assign tx_ready   = (state_q == TX_IDLE);
  assign tx_busy    = (state_q != TX_IDLE);

endmodule

// File: tb/tb_cia_serial_link.sv
// ---------------------------------------------------------------------------
// tb_cia_serial_link
//
// Self-checking bench for cia_serial_link. A behavioural model holds the
// bytes expected on the RX consumer side (queue) and the bits expected on
// the TX pins (queue, MSB-first); one monitor process compares the DUT
// against it every cycle. Directed cases pin literal values; a randomized
// phase runs RX and TX concurrently.
// ---------------------------------------------------------------------------
module tb_cia_serial_link;

  localparam int CNT_DIV      = 8;
  localparam int FIFO_DEPTH   = 4;
  localparam int IDLE_TIMEOUT = 1024;
  localparam int TX_LEN       = 17 * CNT_DIV;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       cia_sp_out = 1'b1;
  logic       cia_cnt_out = 1'b1;
  logic       cia_sp_in, cia_cnt_in;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy;
`ifdef CIA_LINK_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  cia_serial_link #(
    .CNT_DIV(CNT_DIV), .FIFO_DEPTH(FIFO_DEPTH), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .res_n(res_n),
`ifdef CIA_LINK_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cia_sp_out(cia_sp_out), .cia_cnt_out(cia_cnt_out),
    .cia_sp_in(cia_sp_in), .cia_cnt_in(cia_cnt_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0] rx_q[$];     // bytes the consumer must see, in order
  bit         tx_q[$];     // bits the CIA must sample at CNT rising edges
  int         ov_seen   = 0;
  int         exp_ov    = 0;
  int         tx_rises  = 0;
  logic [7:0] tx_cap    = 8'h00;
  logic       prev_cnt_in = 1'b1;
  bit         mon_en    = 1'b0;
  bit         lb_hold   = 1'b0;

  // Per-cycle compare of the DUT against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) fail_now("rx_pop_unexpected");
        else check("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
      end else if (rx_q.size() == 0) begin
        check("rx_valid_idle", {31'h0, rx_valid}, 32'h0);
      end
      if (rx_overrun) ov_seen++;
      check("tx_busy", {31'h0, tx_busy}, {31'h0, !tx_ready});
      if (lb_hold) check("lb_cnt_in", {31'h0, cia_cnt_in}, 32'h1);
      if (cia_cnt_in && !prev_cnt_in) begin
        tx_rises++;
        tx_cap = {tx_cap[6:0], cia_sp_in};
        if (tx_q.size() == 0) fail_now("tx_edge_unexpected");
        else check("tx_bit", {31'h0, cia_sp_in}, {31'h0, tx_q.pop_front()});
      end
      prev_cnt_in = cia_cnt_in;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic rx_bit(input logic b, input int lo, input int hi);
    @(posedge clk); #2;
    cia_sp_out  = b;
    cia_cnt_out = 1'b0;
    repeat (lo) @(posedge clk);
    #2 cia_cnt_out = 1'b1;
    repeat (hi) @(posedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b, input int lo, input int hi);
    if (rx_q.size() >= FIFO_DEPTH) exp_ov++;
    else rx_q.push_back(b);
    for (int i = 7; i >= 0; i--) rx_bit(b[i], lo, hi);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    @(negedge clk);
    while (!rx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!rx_valid) fail_now(name);
  endtask

  task automatic drain();
    int k = 0;
    @(posedge clk); #2 rx_ready = 1'b1;
    @(negedge clk);
    while (!(rx_q.size() == 0 && !rx_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (rx_q.size() != 0 || rx_valid) fail_now("drain_timeout");
    @(posedge clk); #2 rx_ready = 1'b0;
  endtask

  // Call on a falling edge; returns on the falling edge where tx_ready is back
  task automatic tx_send(input logic [7:0] b, input bit model_it,
                         output int waited, output int len);
    tx_data  = b;
    tx_valid = 1'b1;
    waited   = 0;
    len      = 0;
    while (!tx_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) begin
      fail_now("tx_accept_timeout");
      tx_valid = 1'b0;
      return;
    end
    if (model_it) for (int i = 7; i >= 0; i--) tx_q.push_back(b[i]);
    @(posedge clk); #1 tx_valid = 1'b0;
    do begin
      @(negedge clk);
      if (!tx_ready) len++;
    end while (!tx_ready && len < 3000);
  endtask

  bit rx_done, tx_done;

  initial begin
    int w, len, ov0;

    // Reset with random inputs
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #2;
      cia_sp_out  = 1'($urandom_range(0, 1));
      cia_cnt_out = 1'($urandom_range(0, 1));
      rx_ready    = 1'($urandom_range(0, 1));
      tx_data     = 8'($urandom);
      tx_valid    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_sp_in",   {31'h0, cia_sp_in},  32'h1);
      check("rst_cnt_in",  {31'h0, cia_cnt_in}, 32'h1);
      check("rst_rx_valid",{31'h0, rx_valid},   32'h0);
      check("rst_rx_data", {24'h0, rx_data},    32'h0);
      check("rst_overrun", {31'h0, rx_overrun}, 32'h0);
      check("rst_tx_ready",{31'h0, tx_ready},   32'h1);
    end
    cia_sp_out = 1'b1; cia_cnt_out = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_sp_in",   {31'h0, cia_sp_in},  32'h1);
      check("post_rst_cnt_in",  {31'h0, cia_cnt_in}, 32'h1);
      check("post_rst_rx_valid",{31'h0, rx_valid},   32'h0);
      check("post_rst_tx_ready",{31'h0, tx_ready},   32'h1);
    end
    mon_en = 1'b1;

    // Single RX byte
    rx_byte(8'hA5, 10, 10);
    wait_valid("rx_a5_valid_timeout");
    check("rx_a5_lit", {24'h0, rx_data}, 32'hA5);
    drain();

    // Overrun: five bytes into a four-entry FIFO with no consumer
    ov0 = ov_seen;
    for (int i = 1; i <= 5; i++) rx_byte(8'(i), 10, 10);
    repeat (10) @(negedge clk);
    check("ovr_pulses", ov_seen - ov0, 32'd1);
    check("ovr_head_lit", {24'h0, rx_data}, 32'h01);
    drain();

    // Timeout: three stray bits, long CNT-high idle, then a full byte
    rx_bit(1'b1, 10, 10);
    rx_bit(1'b0, 10, 10);
    rx_bit(1'b1, 10, 10);
    repeat (1100) @(posedge clk);
    rx_byte(8'h3C, 10, 10);
    wait_valid("rx_3c_valid_timeout");
    check("rx_3c_lit", {24'h0, rx_data}, 32'h3C);
    drain();

    // TX 0xC3 then a back-to-back second byte
    @(negedge clk);
    tx_cap = 8'h00; tx_rises = 0;
    tx_send(8'hC3, 1'b1, w, len);
    check("tx_c3_len", len, TX_LEN);
    check("tx_c3_bits_lit", {24'h0, tx_cap}, 32'hC3);
    check("tx_c3_pulses", tx_rises, 32'd8);
    tx_send(8'h3A, 1'b1, w, len);
    check("tx_b2b_wait", w, 32'd0);
    check("tx_b2b_len", len, TX_LEN);

    // Randomized concurrent RX and TX traffic
    rx_done = 1'b0; tx_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          rx_byte(8'($urandom), $urandom_range(3, 12), $urandom_range(3, 12));
          repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        rx_done = 1'b1;
      end
      begin
        int tw, tl;
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(1, 20)) @(negedge clk);
          tx_send(8'($urandom), 1'b1, tw, tl);
          check("tx_rand_len", tl, TX_LEN);
        end
        tx_done = 1'b1;
      end
      begin
        while (!(rx_done && tx_done)) begin
          @(posedge clk); #2 rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

`ifdef CIA_LINK_LOOPBACK_EN
    // Loopback: TX feeds RX internally, CIA pins stay parked high
    @(negedge clk) loopback = 1'b1;
    repeat (3) @(negedge clk);
    lb_hold = 1'b1;
    rx_q.push_back(8'h5A);
    tx_send(8'h5A, 1'b0, w, len);
    wait_valid("lb_valid_timeout");
    check("lb_rx_lit", {24'h0, rx_data}, 32'h5A);
    lb_hold = 1'b0;
    @(negedge clk) loopback = 1'b0;
    drain();
`endif

    repeat (5) @(negedge clk);
    check("rx_model_empty", rx_q.size(), 32'd0);
    check("tx_model_empty", tx_q.size(), 32'd0);
    check("ovr_total", ov_seen, exp_ov);
    check("ovr_total_lit", exp_ov, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Hard stop if anything hangs
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cia_serial_link.md
Name: cia_serial_link

Overview:
- Peer endpoint for the CIA serial port (SP/CNT); sits directly on the CIA's sp_out/cnt_out and sp_in/cnt_in pins.
- RX path: deserializes bytes the CIA shifts out in output mode into a small FIFO with a valid/ready interface.
- TX path: serializes bytes from a valid/ready interface onto sp_in/cnt_in so a CIA in input mode receives them, raising its SDR interrupt.
- Used to bridge the 6502 system's CIA serial port to host-side logic such as a UART or debug link.

Parameters:
CNT_DIV, 8, clk cycles per CNT half-period when transmitting; integer >=1; must be >= 2 phi2 periods in clk cycles so the CIA sees every edge
FIFO_DEPTH, 4, RX FIFO entries; power of two, >=2
IDLE_TIMEOUT, 1024, clk cycles of CNT-high inactivity after which a partial RX byte is discarded

Ports:
clk  in  1  system clock
res_n  in  1  asynchronous active-low reset
cia_sp_out  in  1  CIA SP output (data)
cia_cnt_out  in  1  CIA CNT output (shift clock, idle high)
cia_sp_in  out  1  drives CIA SP input
cia_cnt_in  out  1  drives CIA CNT input
rx_data  out  8  FIFO head byte
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pops head when rx_valid&rx_ready
rx_overrun  out  1  one-cycle pulse: received byte dropped, FIFO full
tx_data  in  8  byte to send
tx_valid  in  1  byte offered
tx_ready  out  1  transmitter idle; accept on tx_valid&tx_ready
tx_busy  out  1  transmission in progress (inverse of tx_ready)

Behaviour:
- Reset (async, res_n=0): cia_sp_in=1, cia_cnt_in=1, rx_valid=0, rx_data=0x00, rx_overrun=0, tx_ready=1, tx_busy=0. FIFO is emptied, partial RX byte discarded, TX aborted. Synchronizers load 1.
- RX synchronization: cia_cnt_out and cia_sp_out each pass through 2 flops. A rising edge is detected on the synchronized CNT.
  - On the edge, shift in the synchronized SP MSB-first: shreg <= {shreg[6:0], sp}. The 3-bit counter increments.
  - When the counter wraps 7->0, the completed byte is pushed. Push occurs on the clk after the 8th rising edge is detected, i.e. 3-4 clk after the pin edge.
- RX timeout: counter clears on any synchronized CNT edge. If the bit count is nonzero and CNT stays high for IDLE_TIMEOUT cycles, clear the bit count and shreg. A low CNT does not advance the timeout.
- RX FIFO: registered; rx_data/rx_valid reflect the head.
  - Push to a full FIFO with no simultaneous pop: byte dropped, rx_overrun=1 for one cycle.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push into empty: rx_valid=1 the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- TX FSM states:
  - IDLE: tx_ready=1, cnt_in=1. On tx_valid: load shreg=tx_data, bit=0, go to LOW.
  - LOW: cia_sp_in=shreg[7], cnt_in=0 for CNT_DIV cycles, then go to HIGH.
  - HIGH: cnt_in=1 for CNT_DIV cycles. On exit: shreg<<=1, bit++. If bit was 7, go to GAP; else go to LOW.
  - GAP: cnt_in=1 for CNT_DIV cycles, then go to IDLE. cia_sp_in returns to 1 on entering GAP.
- TX timing: cia_cnt_in falls on the first clk after acceptance. A byte occupies exactly 17*CNT_DIV clk cycles from acceptance to tx_ready reasserting.
- TX data stability: the data bit is stable for the full LOW and HIGH phases, so it is valid at the CNT rising edge the CIA samples.
- TX/RX independence: both paths run concurrently and do not interact.
- Divider: single down-counter reloaded with CNT_DIV-1 on each state entry.

Optional Feature:
CIA_LINK_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1:
  - The RX synchronizer inputs take the internal TX sp/cnt values instead of cia_sp_out/cia_cnt_out.
  - cia_sp_in and cia_cnt_in are held at 1.
  - A change of loopback takes effect at the next clk; switching mid-byte may corrupt that byte, which the RX timeout then recovers from.
- Not defined: no loopback port; RX always uses the CIA pins.

Test Plan:
- Reset: hold res_n=0 with random inputs -> cia_sp_in=1, cia_cnt_in=1, rx_valid=0, tx_ready=1; release -> unchanged until stimulus.
- RX byte: drive 8 CNT pulses (high/low 10 clk each) with SP=0xA5 MSB-first -> rx_valid rises with rx_data=0xA5; pop -> rx_valid=0.
- RX overrun: FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 -> fifth byte gives one rx_overrun pulse; pops return 0x01,0x02,0x03,0x04.
- RX timeout: send 3 bits, hold CNT high 1100 clk, then send 0x3C -> only 0x3C is received.
- TX: CNT_DIV=8, offer 0xC3 -> cia_cnt_in shows 8 low pulses; cia_sp_in sampled at each rising edge gives 1,1,0,0,0,0,1,1; tx_ready back after 136 clk. A back-to-back second byte is accepted on that cycle.
- Loopback (macro defined, loopback=1): send 0x5A via TX -> rx_data=0x5A; cia_cnt_in stays 1 throughout.
